// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and helpers for the instruction fetch queue: FSM encoding,
// queue entry layout and the static JAL next-PC computation.
package inst_fetch_queue_pkg;

    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        IFQ_IDLE = 2'd0,
        IFQ_REQ  = 2'd1,
        IFQ_WAIT = 2'd2
    } ifq_state_e;

    typedef struct packed {
        addr_t       pc;
        logic [31:0] inst;
    } ifq_entry_t;

    localparam logic [6:0] OPCODE_JAL = 7'b1101111;

    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // JAL targets are followed without waiting for the backend.
    function automatic addr_t next_pc(input addr_t pc, input logic [31:0] inst);
        if (inst[6:0] == OPCODE_JAL) begin
            return pc + j_imm(inst);
        end
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_inst_queue.sv
// Circular in-order FIFO of {pc, inst} entries with synchronous flush.
// Head entry is presented combinationally; it reads as zero while empty.
module inst_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  ifq_entry_t              push_entry_i,
    input  logic                    pop_i,
    output ifq_entry_t              head_o,
    output logic                    valid_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    ifq_entry_t          mem_q [DEPTH];
    logic [AW-1:0]       head_q, head_d;
    logic [AW-1:0]       tail_q, tail_d;
    logic [AW:0]         count_q, count_d;
    logic                do_push;
    logic                do_pop;

    assign do_push = en_i && !flush_i && push_i;
    assign do_pop  = en_i && !flush_i && pop_i && (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (en_i && flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PTR_ONE;
            if (do_pop)  head_d = head_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[head_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: PC, single-outstanding icache request FSM and redirect
// handling, feeding an in-order {pc, inst} queue towards the decoder.
//
//   state    | meaning
//   IFQ_IDLE | no request outstanding; waits for queue room
//   IFQ_REQ  | request presented at pc, waiting for icache accept
//   IFQ_WAIT | accepted, waiting for the word (discarded if drop set)
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int    QUEUE_DEPTH = 16,
    parameter addr_t RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rstn_in,
    input  logic        rdy_in,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_req_ready,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

    ifq_state_e  state_q, state_d;
    addr_t       pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        push, pop, flush;
    ifq_entry_t  push_entry, head;
    logic        head_valid;
    logic [CW-1:0] count;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        push    = 1'b0;
        flush   = 1'b0;
        pop     = head_valid && dec_ready && !redirect_valid;

        case (state_q)
            IFQ_IDLE: begin
                if (count < FULL_CNT) state_d = IFQ_REQ;
            end
            IFQ_REQ: begin
                if (icache_req_ready) state_d = IFQ_WAIT;
            end
            IFQ_WAIT: begin
                if (icache_resp_valid) begin
                    state_d = IFQ_IDLE;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        push = 1'b1;
                        pc_d = next_pc(pc_q, icache_resp_inst);
                    end
                end
            end
            default: state_d = IFQ_IDLE;
        endcase

        // A word still owed by the icache must be swallowed after a flush.
        if (redirect_valid) begin
            flush = 1'b1;
            push  = 1'b0;
            pc_d  = redirect_pc;
            if (state_q == IFQ_WAIT && !icache_resp_valid) begin
                state_d = IFQ_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = IFQ_IDLE;
                drop_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q <= IFQ_IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    assign push_entry = '{pc: pc_q, inst: icache_resp_inst};

    inst_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_inst_queue (
        .clk_i        (clk_in),
        .rst_ni       (rstn_in),
        .en_i         (rdy_in),
        .flush_i      (flush),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .valid_o      (head_valid),
        .count_o      (count)
    );

    assign icache_req_valid = (state_q == IFQ_REQ);
    assign icache_req_addr  = pc_q;
    assign dec_valid        = head_valid;
    assign dec_pc           = head.pc;
    assign dec_inst         = head.inst;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: behavioural icache with adjustable
// latency, and a scoreboard of expected {pc, inst} checked on every pop.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rdy;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_inst = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .QUEUE_DEPTH (16),
        .RESET_PC    (32'h0)
    ) dut (
        .clk_in            (clk),
        .rstn_in           (rstn),
        .rdy_in            (rdy),
        .icache_req_valid  (req_valid),
        .icache_req_addr   (req_addr),
        .icache_req_ready  (req_ready),
        .icache_resp_valid (resp_valid),
        .icache_resp_inst  (resp_inst),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .dec_valid         (dec_valid),
        .dec_inst          (dec_inst),
        .dec_pc            (dec_pc),
        .dec_ready         (dec_ready)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic [31:0] acc_log[$];
    int          lat = 1;
    int          wait_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] JAL_P20 = 32'h0200006F;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a == 32'h10) ? JAL_P20 : NOP;
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] p);
        return (imem(p) == JAL_P20) ? p + 32'h20 : p + 32'h4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] start, input int n);
        logic [31:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{pc: p, inst: imem(p)});
            p = ref_next(p);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns just after the accepting edge, i.e. with the DUT in WAIT.
    task automatic wait_accept(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (rstn && rdy && req_valid && req_ready && !redirect_valid) ok = 1'b1;
        end
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL wait_accept observed=timeout expected=accept within %0d cycles", max);
        end
        @(posedge clk);
        #1;
    endtask

    // icache: a response appears lat cycles after the accepting edge.
    always @(negedge clk) begin
        resp_valid = 1'b0;
        if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                resp_valid = 1'b1;
                resp_inst  = imem(pend_addr);
            end
        end
        if (rstn && rdy && req_valid && req_ready && !redirect_valid) begin
            pend_addr = req_addr;
            wait_cnt  = lat;
            acc_log.push_back(req_addr);
        end
    end

    // Every pop is checked against the scoreboard while it holds entries.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && rdy && dec_valid && dec_ready && !redirect_valid) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("dec_pc", dec_pc, e.pc);
                chk("dec_inst", dec_inst, e.inst);
            end
        end
    end

    initial begin
        rstn           = 1'b0;
        rdy            = 1'b1;
        req_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b1;

        // reset state
        #12;
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst_dec_inst", dec_inst, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);

        // nop stream from reset, including the JAL at 0x10
        push_exp(32'h0, 7);
        @(posedge clk);
        #3 rstn = 1'b1;
        cyc(2);
        chk("first_valid_early", {31'b0, dec_valid}, 32'd0);
        cyc(1);
        chk("first_valid", {31'b0, dec_valid}, 32'd1);
        chk("first_pc", dec_pc, 32'h0);
        cyc(25);
        chk("stream_drained", sb.size(), 32'd0);
        chk("acc_jal_src", acc_log[4], 32'h10);
        chk("acc_jal_tgt", acc_log[5], 32'h30);
        chk("acc_after_tgt", acc_log[6], 32'h34);

        // redirect in WAIT with a slow response that must be dropped
        acc_log.delete();
        lat = 3;
        wait_accept(20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        sb.delete();
        push_exp(32'h100, 3);
        lat = 1;
        acc_log.delete();
        cyc(1);
        redirect_valid = 1'b0;
        chk("redir_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("redir_req_valid", {31'b0, req_valid}, 32'd0);
        cyc(20);
        chk("redir_acc0", acc_log[0], 32'h100);
        chk("redir_drained", sb.size(), 32'd0);

        // back-pressure until full, then drain in order
        dec_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        sb.delete();
        push_exp(32'h200, 16);
        cyc(1);
        redirect_valid = 1'b0;
        acc_log.delete();
        cyc(100);
        chk("full_req_valid", {31'b0, req_valid}, 32'd0);
        chk("full_dec_valid", {31'b0, dec_valid}, 32'd1);
        chk("full_head_pc", dec_pc, 32'h200);
        chk("full_fetches", acc_log.size(), 32'd16);
        dec_ready = 1'b1;
        cyc(20);
        chk("full_drained", sb.size(), 32'd0);
        chk("full_resume", acc_log[16], 32'h240);

        // global stall while a request is presented
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        sb.delete();
        cyc(1);
        redirect_valid = 1'b0;
        acc_log.delete();
        cyc(1);
        chk("stall_req_valid", {31'b0, req_valid}, 32'd1);
        chk("stall_req_addr", req_addr, 32'h400);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("stall_hold_valid", {31'b0, req_valid}, 32'd1);
            chk("stall_hold_addr", req_addr, 32'h400);
            chk("stall_no_accept", acc_log.size(), 32'd0);
        end
        rdy = 1'b1;
        push_exp(32'h400, 3);
        cyc(12);
        chk("stall_acc0", acc_log[0], 32'h400);
        chk("stall_drained", sb.size(), 32'd0);

        // asynchronous reset in WAIT with three entries queued
        dec_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        sb.delete();
        cyc(1);
        redirect_valid = 1'b0;
        cyc(8);
        wait_accept(10);
        chk("pre_rst_dec_valid", {31'b0, dec_valid}, 32'd1);
        chk("pre_rst_dec_pc", dec_pc, 32'h500);
        #1 rstn = 1'b0;
        #1;
        chk("arst_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("arst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("arst_req_addr", req_addr, 32'h0);
        push_exp(32'h0, 3);
        dec_ready = 1'b1;
        acc_log.delete();
        #1 rstn = 1'b1;
        cyc(15);
        chk("arst_drained", sb.size(), 32'd0);
        chk("arst_acc0", acc_log[0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
